mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one memory_controller port between NUM_REQ requesters, e.g. cache_controller refill/writeback and an instruction-fetch path in cpu_system.
- Round-robin arbitration; one transaction outstanding at a time.
- Sequences the memory_controller enables (single-cycle enable pulse, then wait for registered ready) and routes the response back to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, WAIT-state cycle limit (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request; held stable until req_ready
- req_write  in  NUM_REQ  per-requester 1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- mem_read  out  1  to memory read_enable
- mem_write  out  1  to memory write_enable
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write_data
- mem_rdata  in  DATA_W  from memory read_data
- mem_ready  in  1  from memory ready

Behaviour:
- One clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - state=IDLE; all outputs 0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Latched address, write data and write flag cleared.
- Reset mid-transaction: the transaction is abandoned with no rsp_valid. The memory may still raise mem_ready the next cycle; it is ignored in IDLE.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid, grant g = first set bit scanning from last_grant+1 upward, with modulo NUM_REQ wrap.
  - req_ready[g]=1 that cycle; req_ready is combinational from state and req_valid.
  - Latch req_addr[g], req_wdata[g], req_write[g] and g; go to ISSUE.
  - Only one req_ready bit is ever set.
- ISSUE:
  - mem_read = !write_l, mem_write = write_l, for exactly one cycle. Both are registered; they are never high together.
  - mem_addr and mem_wdata show the latched values from ISSUE through WAIT; they are 0 in IDLE.
  - Go to WAIT.
- WAIT:
  - Enables low. On mem_ready=1: capture mem_rdata into rsp_rdata (0 for writes), set last_grant=g, go to IDLE.
  - Next cycle: rsp_valid[g]=1 for one cycle, rsp_err=0.
- Timing:
  - Accept in cycle N, enable in N+1, mem_ready in N+2, rsp_valid in N+3.
  - A new accept may occur in N+3 (same cycle as rsp_valid), giving 3 cycles per transaction back-to-back.
- rsp_rdata holds its value until the next completion.
- mem_ready seen in IDLE or ISSUE is ignored.
- Requests deasserted before req_ready are legal and simply not granted.
- Fairness: under continuous requests from all NUM_REQ requesters, each is granted once per NUM_REQ transactions.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A 5-bit-minimum counter (width clog2(TIMEOUT+1)) clears on entry to WAIT and increments each WAIT cycle without mem_ready.
  - When it reaches TIMEOUT, go to IDLE and pulse rsp_valid[g] with rsp_err=1 and rsp_rdata=0; last_grant updates as normal.
  - mem_ready arriving in the same cycle as the limit takes precedence: normal completion, rsp_err=0.
- Undefined: no counter; WAIT blocks indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset, then requester 0 read at addr 0x0000_0040 with memory returning 0xDEAD_BEEF:
  - req_ready[0] in cycle 0, mem_read=1 only in cycle 1, rsp_valid=2'b01 and rsp_rdata=0xDEAD_BEEF in cycle 3.
- Requesters 0 and 1 both request continuously, 6 transactions:
  - Grant order 0,1,0,1,0,1; completions spaced exactly 3 cycles apart; req_ready one-hot throughout.
- Requester 1 writes 0x1234_5678 to 0x0000_0100, then requester 0 reads 0x0000_0100:
  - mem_write=1 with mem_wdata=0x1234_5678 for one cycle; the read returns 0x1234_5678.
- Assert rst_n=0 for one cycle while in WAIT:
  - No rsp_valid.
  - Next request from requester 1 alone is granted; requester 0 is granted first if both request.
- mem_ready forced high in IDLE with no requests: no state change, no rsp_valid.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=16, hold mem_ready low:
  - rsp_err=1, rsp_rdata=0 exactly 17 cycles after ISSUE; the arbiter then accepts the next request.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory port between NUM_REQ requesters.
// Optional WAIT timeout with error response when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 5) ? 5 : CW_RAW;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  logic                found;
  logic [GW-1:0]       pick;
  int                  sum;

  // Round-robin search starting just past the last completed grant
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last_grant_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      if (!found && req_valid[GW'(sum)]) begin
        found = 1'b1;
        pick  = GW'(sum);
      end
    end
  end

  // Accept pulse goes straight to the chosen requester while idle
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && found) begin
      req_ready[pick] = 1'b1;
    end
  end

  // Next-state and registered-output logic for the transaction FSM
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d     = pick;
          addr_d      = req_addr[pick*ADDR_W +: ADDR_W];
          wdata_d     = req_wdata[pick*DATA_W +: DATA_W];
          write_d     = req_write[pick];
          mem_read_d  = !req_write[pick];
          mem_write_d = req_write[pick];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (mem_ready) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_rdata_d  = write_q ? '0 : mem_rdata;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_rdata_d  = '0;
          rsp_err_d    = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // WAIT-cycle counter and error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = (state_q != IDLE) ? addr_q : '0;
  assign mem_wdata = (state_q != IDLE) ? wdata_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
